// File: rtl/risc8_io_bank_if.sv
// rtl/risc8_io_bank_if.sv - core data-bus view of the risc8 IO bank
interface risc8_io_bank_if;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;

    modport master (output addr, wen, ren, wdata, input rdata, sel);
    modport slave  (input addr, wen, ren, wdata, output rdata, sel);
endinterface

// File: rtl/risc8_io_bank.sv
// rtl/risc8_io_bank.sv - risc8 IO window: GPIO ports plus 8-bit timer with compare and interrupt
module risc8_io_bank #(
    parameter int         PORTS     = 1,
    parameter logic [6:0] GPIO_BASE = 7'h36,
    parameter logic [6:0] TMR_BASE  = 7'h4B
) (
    input  logic                 clk,
    input  logic                 reset,
    risc8_io_bank_if.slave       bus,
    input  logic [8*PORTS-1:0]   pin_in,
    output logic [8*PORTS-1:0]   port_out,
    output logic [8*PORTS-1:0]   ddr_out,
    output logic                 irq
);
    localparam int W = 8 * PORTS;

    logic         io, wr, rd;
    logic [6:0]   io_addr;

    logic [W-1:0] port_q, ddr_q, sync1, sync2;
    logic [W-1:0] port_d, ddr_d;

    logic [7:0]   tcnt, ocr, tcnt_d;
    logic [3:0]   tccr;
    logic [1:0]   tifr, timsk, tifr_d, tifr_set, tifr_clr;
    logic [9:0]   presc, presc_d, limit;
    logic         running, tick, tick_eff, ocr_match;
    logic         timsk_wr, tifr_wr, ocr_wr, tccr_wr, tcnt_wr;

    logic [7:0]   rdata_q, rd_val;
    logic         sel_q, irq_q;

    function automatic logic [6:0] pin_addr(input int k);
        return GPIO_BASE + 7'(3 * k);
    endfunction

    assign io      = (bus.wen | bus.ren) && (bus.addr < 16'h0060);
    assign io_addr = bus.addr[6:0];
    assign wr      = io && bus.wen;
    assign rd      = io && bus.ren;

    assign timsk_wr = wr && (io_addr == TMR_BASE);
    assign tifr_wr  = wr && (io_addr == TMR_BASE + 7'd1);
    assign ocr_wr   = wr && (io_addr == TMR_BASE + 7'd2);
    assign tccr_wr  = wr && (io_addr == TMR_BASE + 7'd3);
    assign tcnt_wr  = wr && (io_addr == TMR_BASE + 7'd4);

    // A PIN write toggles PORT; the PIN value itself only comes from the synchroniser.
    always_comb begin
        port_d = port_q;
        ddr_d  = ddr_q;
        for (int k = 0; k < PORTS; k++) begin
            if (wr && io_addr == pin_addr(k))
                port_d[8*k +: 8] = port_q[8*k +: 8] ^ bus.wdata;
            if (wr && io_addr == pin_addr(k) + 7'd1)
                ddr_d[8*k +: 8] = bus.wdata;
            if (wr && io_addr == pin_addr(k) + 7'd2)
                port_d[8*k +: 8] = bus.wdata;
        end
    end

    always_comb begin
        limit   = 10'd0;
        running = 1'b1;
        case (tccr[2:0])
            3'd1:    limit = 10'd0;
            3'd2:    limit = 10'd7;
            3'd3:    limit = 10'd63;
            3'd4:    limit = 10'd255;
            3'd5:    limit = 10'd1023;
            default: running = 1'b0;
        endcase
    end

    assign tick      = running && (presc == limit);
    assign tick_eff  = tick && !tcnt_wr;
    assign ocr_match = (tcnt == ocr);

    always_comb begin
        presc_d = presc;
        if (tccr_wr || tick)
            presc_d = 10'd0;
        else if (running)
            presc_d = presc + 10'd1;

        tcnt_d = tcnt;
        if (tcnt_wr)
            tcnt_d = bus.wdata;
        else if (tick)
            tcnt_d = (tccr[3] && ocr_match) ? 8'h00 : tcnt + 8'd1;

        // Flags raised by a tick survive a write-1-clear in the same cycle.
        tifr_set = {tick_eff && ocr_match, tick_eff && (tcnt == 8'hFF)};
        tifr_clr = tifr_wr ? bus.wdata[1:0] : 2'b00;
        tifr_d   = (tifr & ~tifr_clr) | tifr_set;
    end

    always_comb begin
        rd_val = 8'h00;
        for (int k = 0; k < PORTS; k++) begin
            if (io_addr == pin_addr(k))         rd_val = sync2[8*k +: 8];
            if (io_addr == pin_addr(k) + 7'd1)  rd_val = ddr_q[8*k +: 8];
            if (io_addr == pin_addr(k) + 7'd2)  rd_val = port_q[8*k +: 8];
        end
        if (io_addr == TMR_BASE)         rd_val = {6'b0, timsk};
        if (io_addr == TMR_BASE + 7'd1)  rd_val = {6'b0, tifr};
        if (io_addr == TMR_BASE + 7'd2)  rd_val = ocr;
        if (io_addr == TMR_BASE + 7'd3)  rd_val = {4'b0, tccr};
        if (io_addr == TMR_BASE + 7'd4)  rd_val = tcnt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_q  <= '0;
            ddr_q   <= '0;
            sync1   <= '0;
            sync2   <= '0;
            tcnt    <= 8'h00;
            ocr     <= 8'hFF;
            tccr    <= 4'h0;
            tifr    <= 2'b00;
            timsk   <= 2'b00;
            presc   <= 10'd0;
            rdata_q <= 8'h00;
            sel_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync1  <= pin_in;
            sync2  <= sync1;
            port_q <= port_d;
            ddr_q  <= ddr_d;
            tcnt   <= tcnt_d;
            presc  <= presc_d;
            tifr   <= tifr_d;
            if (ocr_wr)   ocr   <= bus.wdata;
            if (tccr_wr)  tccr  <= bus.wdata[3:0];
            if (timsk_wr) timsk <= bus.wdata[1:0];
            if (rd)       rdata_q <= rd_val;
            sel_q <= io;
            irq_q <= |(tifr & timsk);
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.sel   = sel_q;
    assign port_out  = port_q;
    assign ddr_out   = ddr_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_risc8_io_bank.sv
// tb/tb_risc8_io_bank.sv - directed bench for risc8_io_bank with four GPIO ports
module tb_risc8_io_bank;
    localparam logic [15:0] PIN0 = 16'h0036, DDR0 = 16'h0037, PORT0 = 16'h0038;
    localparam logic [15:0] PORT1 = 16'h003B, PORT3 = 16'h0041;
    localparam logic [15:0] TIMSK = 16'h004B, TIFR = 16'h004C, OCR = 16'h004D;
    localparam logic [15:0] TCCR = 16'h004E, TCNT = 16'h004F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pin_in;
    logic [31:0] port_out, ddr_out;
    logic        irq;
    int          n_checks = 0;
    int          n_pass = 0;

    risc8_io_bank_if bus ();

    risc8_io_bank #(.PORTS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .pin_in   (pin_in),
        .port_out (port_out),
        .ddr_out  (ddr_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Each bus task starts at a falling edge and returns at the next one.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.addr = a; bus.wdata = d; bus.wen = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.addr = a; bus.ren = 1'b1;
        @(negedge clk);
        bus.ren = 1'b0;
        d = bus.rdata;
    endtask

    task automatic rdwr(input logic [15:0] a, input logic [7:0] wd, output logic [7:0] d);
        bus.addr = a; bus.wdata = wd; bus.wen = 1'b1; bus.ren = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0; bus.ren = 1'b0;
        d = bus.rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        int         hits, first_hit, gap;
        logic [7:0] acc;

        reset = 1'b0; pin_in = '0;
        bus.addr = '0; bus.wen = 1'b0; bus.ren = 1'b0; bus.wdata = '0;
        idle(3);
        check("reset port_out", port_out, 32'h0);
        check("reset ddr_out", ddr_out, 32'h0);
        check("reset rdata", {24'h0, bus.rdata}, 32'h0);
        check("reset sel", {31'h0, bus.sel}, 32'h0);
        check("reset irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;
        idle(1);

        wr(DDR0, 8'hFF);
        check("ddr0 write", ddr_out, 32'h0000_00FF);
        wr(PORT0, 8'hA5);
        check("port0 write", port_out, 32'h0000_00A5);
        wr(PIN0, 8'h0F);
        check("pin0 toggle", port_out, 32'h0000_00AA);
        rd(DDR0, d);  check("ddr0 read", {24'h0, d}, 32'h0000_00FF);
        rd(PORT0, d); check("port0 read", {24'h0, d}, 32'h0000_00AA);

        pin_in = 32'h0000_003C;
        idle(2);
        rd(PIN0, d);
        check("pin0 sync read", {24'h0, d}, 32'h0000_003C);
        check("pin0 sel", {31'h0, bus.sel}, 32'h1);
        idle(2);
        check("rdata hold idle", {24'h0, bus.rdata}, 32'h0000_003C);
        rd(16'h0070, d);
        check("sel above window", {31'h0, bus.sel}, 32'h0);
        check("rdata hold outside", {24'h0, d}, 32'h0000_003C);
        rd(16'h0060, d);
        check("sel at 0x60", {31'h0, bus.sel}, 32'h0);
        rd(16'h005F, d);
        check("unmapped 0x5F data", {24'h0, d}, 32'h0);
        check("unmapped 0x5F sel", {31'h0, bus.sel}, 32'h1);
        wr(16'h00B8, 8'hFF);
        check("alias write ignored", port_out, 32'h0000_00AA);

        // Overflow from 0xFE at /1, OCR moved off 0xFF so only TOV fires.
        wr(TCNT, 8'hFE);
        wr(OCR, 8'h80);
        wr(TIMSK, 8'h01);
        wr(TCCR, 8'h01);
        idle(1);
        wr(TCCR, 8'h00);
        rd(TCNT, d);  check("tov tcnt", {24'h0, d}, 32'h0);
        rd(TIFR, d);  check("tov tifr", {24'h0, d}, 32'h1);
        check("tov irq", {31'h0, irq}, 32'h1);
        wr(TIFR, 8'h01);
        check("irq lag", {31'h0, irq}, 32'h1);
        idle(1);
        check("irq cleared", {31'h0, irq}, 32'h0);

        // CTC with OCR=4 at /1.
        wr(TIFR, 8'h03);
        wr(TCNT, 8'h00);
        wr(OCR, 8'h04);
        wr(TCCR, 8'h09);
        for (int k = 1; k <= 10; k++) begin
            rd(TCNT, d);
            check($sformatf("ctc tcnt %0d", k), {24'h0, d}, 32'((k - 1) % 5));
        end
        wr(TIFR, 8'h03);
        hits = 0; first_hit = -1; gap = 0; acc = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            rdwr(TIFR, 8'h03, d);
            acc = acc | d;
            if (d[1]) begin
                if (first_hit < 0) first_hit = i;
                else gap = i - first_hit;
                hits++;
            end
        end
        check("ctc ocf count", 32'(hits), 32'd2);
        check("ctc ocf gap", 32'(gap), 32'd5);
        check("ctc no tov", {24'h0, acc}, 32'h2);

        // /8 prescaler, then a TCNT write landing on a tick.
        wr(TCCR, 8'h00);
        wr(TCNT, 8'h00);
        wr(OCR, 8'h02);
        wr(TIFR, 8'h03);
        wr(TCCR, 8'h02);
        for (int k = 1; k <= 17; k++) begin
            rd(TCNT, d);
            check($sformatf("div8 tcnt %0d", k), {24'h0, d}, 32'((k - 1) / 8));
        end
        wr(TIFR, 8'h03);
        idle(5);
        wr(TCNT, 8'h10);
        wr(TCCR, 8'h00);
        rd(TCNT, d);  check("tcnt write wins", {24'h0, d}, 32'h10);
        rd(TIFR, d);  check("no flag on write", {24'h0, d}, 32'h0);

        wr(TCCR, 8'hF8);
        rd(TCCR, d);  check("tccr upper zero", {24'h0, d}, 32'h08);
        wr(TIMSK, 8'hFF);
        rd(TIMSK, d); check("timsk upper zero", {24'h0, d}, 32'h03);

        // Mid-count reset with a concurrent PORT1 write.
        wr(OCR, 8'h33);
        wr(TCCR, 8'h01);
        wr(PORT3, 8'h77);
        check("port3 write", port_out, 32'h7700_00AA);
        idle(3);
        reset = 1'b0;
        bus.addr = PORT1; bus.wdata = 8'hEE; bus.wen = 1'b1;
        @(negedge clk);
        bus.wen = 1'b0;
        check("rst port_out", port_out, 32'h0);
        check("rst ddr_out", ddr_out, 32'h0);
        check("rst irq", {31'h0, irq}, 32'h0);
        check("rst sel", {31'h0, bus.sel}, 32'h0);
        check("rst rdata", {24'h0, bus.rdata}, 32'h0);
        reset = 1'b1;
        rd(TCNT, d);  check("rst tcnt", {24'h0, d}, 32'h0);
        rd(TCCR, d);  check("rst tccr", {24'h0, d}, 32'h0);
        rd(OCR, d);   check("rst ocr", {24'h0, d}, 32'hFF);
        rd(TIFR, d);  check("rst tifr", {24'h0, d}, 32'h0);
        wr(PORT3, 8'h5A);
        check("port3 after reset", port_out, 32'h5A00_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
